sweep_timer: RTL and testbench
==============================

Name: sweep_timer

Overview:
- Parametrised multi-channel successor to the single horizontal sweep counter.
- Each channel is a level-enabled sweep timer with a runtime terminal count, a selectable mode, a busy flag and a one-cycle done pulse.
- Default instance uses two channels: horizontal sweep and vertical sweep. Both are driven by the tracker FSM's sweep enables and report completion back to that FSM.

Parameters:
- WIDTH, 13, counter and limit width in bits.
- CH, 2, number of independent channels.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  CH  per-channel sweep enable (level); low clears the channel.
- MODE  input  CH  per-channel mode: 0 = one-shot, 1 = auto-reload.
- LIMIT  input  WIDTH  shared terminal count, sampled per channel at run entry.
- BUSY  output  CH  per-channel high while the channel is counting.
- DONE  output  CH  per-channel one-cycle pulse at terminal count.
- COUNT  output  CH*WIDTH  per-channel current count; channel i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset: RST_N low forces, asynchronously, every channel to IDLE with COUNT=0, BUSY=0, DONE=0 and latched limit 0. Reset may be asserted mid-run; the next sweep starts cleanly after release.
- Channels are fully independent; no shared state except the LIMIT input.
- States per channel: IDLE, RUN, HOLD.
- IDLE:
  - COUNT=0, BUSY=0.
  - EN=1 sampled at edge k -> RUN at edge k, with COUNT=0, BUSY=1, and LIMIT and MODE latched.
- RUN:
  - COUNT increments by 1 each edge while COUNT != latched limit.
  - Edge where COUNT == latched limit: DONE=1 for exactly that following cycle.
  - One-shot: next state HOLD, BUSY=0, COUNT holds at the limit.
  - Auto-reload: COUNT=0, stays RUN, BUSY stays 1.
- Timing:
  - One-shot: DONE is high in the cycle after edge k+LIMIT+1.
  - Auto-reload period is LIMIT+1 cycles.
- HOLD:
  - COUNT frozen, BUSY=0, DONE=0.
  - Leaves only when EN goes low, then to IDLE.
  - No retrigger without EN going low first.
- EN low in any state: next edge forces IDLE, COUNT=0, BUSY=0, DONE=0.
- Simultaneous EN low and terminal count: EN wins, so DONE is not asserted.
- Limit 0:
  - One-shot: DONE on the edge after entry.
  - Auto-reload: DONE every cycle, COUNT stays 0.
- Maximum limit (all ones): counter never wraps past the limit. Terminal compare precedes increment, so there is no overflow.
- LIMIT or MODE changes during RUN have no effect until the next IDLE -> RUN entry.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - Channel state encoding: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - Mode constants: MODE_ONESHOT=0, MODE_RELOAD=1.
  - Default WIDTH.
- Sub-module sweep_timer_ch:
  - One channel holding state, count, latched limit/mode, BUSY and DONE.
  - Top level generates CH instances and packs COUNT.

Test Plan:
- Reset: RST_N=0 mid-run at COUNT=5 -> COUNT=0, BUSY=0, DONE=0 immediately; after release with EN=0 all remain 0.
- One-shot: WIDTH=13, LIMIT=4, MODE=0, EN rises at edge 0 -> COUNT 0,1,2,3,4; DONE high one cycle after edge 5; BUSY falls at edge 5; COUNT holds 4 until EN drops, then 0.
- Auto-reload: LIMIT=3, MODE=1 -> COUNT 0,1,2,3,0,1…; DONE pulses every 4 cycles; BUSY stays 1.
- EN drop with the channel in RUN at COUNT == latched limit -> no DONE, COUNT=0, IDLE; channel 1 unaffected.
- LIMIT changed 4->10 during RUN -> terminal still at 4; after EN low/high cycle, terminal at 10.
- Boundaries:
  - LIMIT=0, reload: DONE asserted every cycle.
  - LIMIT=8191, one-shot: DONE after 8192 counts, no wrap.

Source files
------------

// File: rtl/sweep_timer_pkg.sv
// sweep_timer_pkg: shared channel state encoding, mode constants and default width.
package sweep_timer_pkg;
  localparam int DEFAULT_WIDTH = 13;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/sweep_timer_ch.sv
// sweep_timer_ch: one level-enabled sweep channel with latched limit/mode, busy flag and done pulse.
module sweep_timer_ch
  import sweep_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] count_o
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, lim_q, lim_d;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
      count_d = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          count_d = '0;
          busy_d  = 1'b1;
          lim_d   = limit_i;
          mode_d  = mode_i;
        end
        ST_RUN: begin
          // Terminal compare comes before the increment, so an all-ones limit never wraps.
          if (count_q == lim_q) begin
            done_d = 1'b1;
            if (mode_q == MODE_RELOAD) count_d = '0;
            else begin
              state_d = ST_HOLD;
              busy_d  = 1'b0;
            end
          end else count_d = count_q + WIDTH'(1);
        end
        ST_HOLD: busy_d = 1'b0;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;
endmodule

// File: rtl/sweep_timer.sv
// sweep_timer: CH independent sweep channels sharing one LIMIT input; counts packed per channel.
module sweep_timer
  import sweep_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CH    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CH-1:0]     en_i,
  input  logic [CH-1:0]     mode_i,
  input  logic [WIDTH-1:0]  limit_i,
  output logic [CH-1:0]     busy_o,
  output logic [CH-1:0]     done_o,
  output logic [CH*WIDTH-1:0] count_o
);
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    sweep_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (en_i[i]),
      .mode_i (mode_i[i]),
      .limit_i(limit_i),
      .busy_o (busy_o[i]),
      .done_o (done_o[i]),
      .count_o(count_o[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_sweep_timer.sv
// tb_sweep_timer: directed stimulus pushes expected outputs; a monitor pops and compares them.
module tb_sweep_timer;
  typedef struct packed {
    logic [1:0]  b;
    logic [1:0]  d;
    logic [12:0] c1;
    logic [12:0] c0;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] en = '0, mode = '0, busy, done;
  logic [12:0] lim = '0;
  logic [25:0] count;
  exp_t q[$];
  string nq[$];
  int tests = 0, fails = 0;
  event sample_ev;
  sweep_timer #(.WIDTH(13), .CH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .limit_i(lim),
    .busy_o(busy), .done_o(done), .count_o(count)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk or sample_ev);
    while (q.size() > 0) begin
      exp_t e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      tests++;
      if ({busy, done, count} !== e) begin
        fails++;
        $display("FAIL %s: got busy=%b done=%b c1=%0d c0=%0d, want busy=%b done=%b c1=%0d c0=%0d",
                 n, busy, done, count[25:13], count[12:0], e.b, e.d, e.c1, e.c0);
      end
    end
  end
  task automatic chk(string n, logic [1:0] b, logic [1:0] d, int c0, int c1);
    q.push_back({b, d, 13'(c1), 13'(c0)});
    nq.push_back(n);
  endtask
  task automatic step(string n, logic [1:0] b, logic [1:0] d, int c0, int c1);
    @(posedge clk);
    #1;
    chk(n, b, d, c0, c1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset", 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    step("idle_after_reset", 2'b00, 2'b00, 0, 0);
    // one-shot, limit 4 on channel 0
    lim = 13'd4; mode = 2'b00; en = 2'b01;
    step("os_entry", 2'b01, 2'b00, 0, 0);
    for (int i = 1; i <= 4; i++) step($sformatf("os_cnt%0d", i), 2'b01, 2'b00, i, 0);
    step("os_done", 2'b00, 2'b01, 4, 0);
    step("os_hold1", 2'b00, 2'b00, 4, 0);
    step("os_hold2", 2'b00, 2'b00, 4, 0);
    en = 2'b00;
    step("os_clear", 2'b00, 2'b00, 0, 0);
    // limit change mid-run is ignored until re-entry
    en = 2'b01;
    step("lc_entry", 2'b01, 2'b00, 0, 0);
    lim = 13'd10;
    for (int i = 1; i <= 4; i++) step($sformatf("lc_cnt%0d", i), 2'b01, 2'b00, i, 0);
    step("lc_done_at4", 2'b00, 2'b01, 4, 0);
    en = 2'b00;
    step("lc_clear", 2'b00, 2'b00, 0, 0);
    en = 2'b01;
    step("lc_entry10", 2'b01, 2'b00, 0, 0);
    for (int i = 1; i <= 10; i++) step($sformatf("lc_cnt10_%0d", i), 2'b01, 2'b00, i, 0);
    step("lc_done_at10", 2'b00, 2'b01, 10, 0);
    en = 2'b00;
    step("lc_clear10", 2'b00, 2'b00, 0, 0);
    // ch0 one-shot and ch1 reload at limit 3; ch0 dropped at its terminal count
    lim = 13'd3; mode = 2'b10; en = 2'b11;
    step("dual_entry", 2'b11, 2'b00, 0, 0);
    for (int j = 1; j <= 3; j++) step($sformatf("dual_cnt%0d", j), 2'b11, 2'b00, j, j);
    en = 2'b10;
    step("drop_at_term", 2'b10, 2'b10, 0, 0);
    for (int j = 1; j <= 8; j++)
      step($sformatf("reload_%0d", j), 2'b10, (j % 4 == 0) ? 2'b10 : 2'b00, 0, j % 4);
    en = 2'b00;
    step("reload_clear", 2'b00, 2'b00, 0, 0);
    // limit 0: reload on ch0 pulses every cycle, one-shot on ch1 pulses once
    lim = 13'd0; mode = 2'b01; en = 2'b01;
    step("z_rl_entry", 2'b01, 2'b00, 0, 0);
    for (int j = 1; j <= 5; j++) step($sformatf("z_rl_%0d", j), 2'b01, 2'b01, 0, 0);
    en = 2'b00;
    step("z_rl_clear", 2'b00, 2'b00, 0, 0);
    mode = 2'b00; en = 2'b10;
    step("z_os_entry", 2'b10, 2'b00, 0, 0);
    step("z_os_done", 2'b00, 2'b10, 0, 0);
    step("z_os_hold", 2'b00, 2'b00, 0, 0);
    en = 2'b00;
    step("z_os_clear", 2'b00, 2'b00, 0, 0);
    // asynchronous reset mid-run at count 5
    lim = 13'd20; en = 2'b01;
    step("ar_entry", 2'b01, 2'b00, 0, 0);
    for (int i = 1; i <= 5; i++) step($sformatf("ar_cnt%0d", i), 2'b01, 2'b00, i, 0);
    @(negedge clk);
    #1 rst_n = 1'b0; en = 2'b00;
    #1 chk("async_rst", 2'b00, 2'b00, 0, 0);
    ->sample_ev;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst_idle", 2'b00, 2'b00, 0, 0);
    lim = 13'd2; en = 2'b01;
    step("post_rst_entry", 2'b01, 2'b00, 0, 0);
    step("post_rst_cnt1", 2'b01, 2'b00, 1, 0);
    step("post_rst_cnt2", 2'b01, 2'b00, 2, 0);
    step("post_rst_done", 2'b00, 2'b01, 2, 0);
    en = 2'b00;
    step("post_rst_clear", 2'b00, 2'b00, 0, 0);
    // maximum limit, one-shot: no wrap past 8191
    lim = 13'd8191; en = 2'b01;
    step("max_entry", 2'b01, 2'b00, 0, 0);
    for (int i = 1; i <= 8191; i++) step($sformatf("max_cnt%0d", i), 2'b01, 2'b00, i, 0);
    step("max_done", 2'b00, 2'b01, 8191, 0);
    step("max_hold", 2'b00, 2'b00, 8191, 0);
    en = 2'b00;
    step("max_clear", 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
